// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: holds one instruction, waits for late load data,
// drives the register-file write port and counts retired instructions.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic        in_link,
    input  logic [4:0]  in_write_reg,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] in_mem_data,
    input  logic        in_mem_ready,
    input  logic        stall_in,
    input  logic        flush,
    output logic        RegWrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {EMPTY, VALID, LOAD_WAIT} state_t;

    state_t      state, next_state;
    logic        reg_write_q;
    logic [4:0]  write_reg_q;
    logic [31:0] write_data_q;
    logic [31:0] count_q;

    logic        accept;
    logic        load_pending;
    logic        count_en;
    logic [31:0] sel_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= next_state;
    end

    always_comb begin
        accept       = in_valid && in_ready && !flush;
        load_pending = in_mem_to_reg && !in_link && !in_mem_ready;
        count_en     = (state == VALID) && !flush;
        if (in_link)            sel_data = in_pc_plus4;
        else if (in_mem_to_reg) sel_data = in_mem_data;
        else                    sel_data = in_alu_result;

        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY, VALID: begin
                    if (accept)              next_state = load_pending ? LOAD_WAIT : VALID;
                    else if (state == VALID) next_state = EMPTY;
                end
                LOAD_WAIT: if (in_mem_ready) next_state = VALID;
                default:   next_state = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready = (state != LOAD_WAIT) && !stall_in;
        RegWrite = (state == VALID) && reg_write_q && (write_reg_q != 5'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            count_q      <= '0;
        end else begin
            if (accept) begin
                reg_write_q <= in_reg_write;
                write_reg_q <= in_write_reg;
                // A pending load keeps the old data visible until it arrives.
                if (!load_pending) write_data_q <= sel_data;
            end else if (state == LOAD_WAIT && in_mem_ready && !flush) begin
                write_data_q <= in_mem_data;
            end
            if (count_en) count_q <= count_q + 32'd1;
        end
    end

    assign write_reg     = write_reg_q;
    assign write_data    = write_data_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven check of mem_wb_stage plus a reset-during-load sequence.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_reg_write, in_mem_to_reg, in_link;
    logic [4:0]  in_write_reg;
    logic [31:0] in_alu_result, in_pc_plus4, in_mem_data;
    logic        in_mem_ready, stall_in, flush;
    logic        RegWrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data, retired_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_link(in_link),
        .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_mem_data(in_mem_data),
        .in_mem_ready(in_mem_ready), .stall_in(stall_in), .flush(flush),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .retired_count(retired_count)
    );

    typedef struct {
        logic        v, rw, m2r, lnk;
        logic [4:0]  wr;
        logic [31:0] alu, pc4, md;
        logic        mrdy, stall, fl;
        logic        e_ready, e_regw;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata, e_cnt;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_ready, input logic e_regw,
                                 input logic [4:0] e_wreg, input logic [31:0] e_wdata,
                                 input logic [31:0] e_cnt);
        chk({tag, " in_ready"},      {31'd0, in_ready}, {31'd0, e_ready});
        chk({tag, " RegWrite"},      {31'd0, RegWrite}, {31'd0, e_regw});
        chk({tag, " write_reg"},     {27'd0, write_reg}, {27'd0, e_wreg});
        chk({tag, " write_data"},    write_data, e_wdata);
        chk({tag, " retired_count"}, retired_count, e_cnt);
    endtask

    task automatic drive(input vec_t t);
        in_valid = t.v; in_reg_write = t.rw; in_mem_to_reg = t.m2r; in_link = t.lnk;
        in_write_reg = t.wr; in_alu_result = t.alu; in_pc_plus4 = t.pc4;
        in_mem_data = t.md; in_mem_ready = t.mrdy; stall_in = t.stall; flush = t.fl;
    endtask

    initial begin
        vec_t idle;
        idle = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
        //          v rw m2r lnk wr  alu           pc4           md            mrdy stall fl | rdy rw wreg wdata      cnt
        vecs[0]  = '{1,1,0,0, 5,  32'hAA,       0,            0,            0,0,0, 1,1, 5, 32'hAA,       0};
        vecs[1]  = '{0,0,0,0, 0,  0,            0,            0,            0,0,0, 1,0, 5, 32'hAA,       1};
        vecs[2]  = '{1,1,0,0, 0,  32'h55,       0,            0,            0,0,0, 1,0, 0, 32'h55,       1};
        vecs[3]  = '{0,0,0,0, 0,  0,            0,            0,            0,0,0, 1,0, 0, 32'h55,       2};
        vecs[4]  = '{1,1,0,0, 3,  32'h77,       0,            0,            0,0,1, 1,0, 0, 32'h55,       2};
        vecs[5]  = '{1,1,1,1, 31, 0,            32'h0040_0008,32'h1111_1111,0,0,0, 1,1, 31,32'h0040_0008,2};
        vecs[6]  = '{1,1,1,0, 9,  0,            0,            32'h1234_5678,1,0,0, 1,1, 9, 32'h1234_5678,3};
        vecs[7]  = '{1,1,0,0, 10, 32'hA0A0,     0,            0,            0,0,0, 1,1, 10,32'hA0A0,     4};
        vecs[8]  = '{1,1,1,0, 8,  0,            0,            32'hBAD,      0,0,0, 0,0, 8, 32'hA0A0,     5};
        vecs[9]  = '{1,1,0,0, 12, 0,            0,            0,            0,0,0, 0,0, 8, 32'hA0A0,     5};
        vecs[10] = '{0,0,0,0, 0,  0,            0,            32'hDEAD_BEEF,1,0,0, 1,1, 8, 32'hDEAD_BEEF,5};
        vecs[11] = '{1,1,0,0, 4,  0,            0,            0,            0,1,0, 0,0, 8, 32'hDEAD_BEEF,6};
        vecs[12] = '{1,1,0,0, 7,  32'h1,        0,            0,            0,0,0, 1,1, 7, 32'h1,        6};
        vecs[13] = '{0,0,0,0, 0,  0,            0,            0,            0,0,1, 1,0, 7, 32'h1,        6};
        vecs[14] = '{1,1,1,0, 2,  0,            0,            0,            0,0,0, 0,0, 2, 32'h1,        6};
        vecs[15] = '{0,0,0,0, 0,  0,            0,            32'hFFFF,     1,0,1, 1,0, 2, 32'h1,        6};
        vecs[16] = '{1,1,1,0, 6,  0,            0,            0,            0,0,0, 0,0, 6, 32'h1,        6};
        vecs[17] = '{0,0,0,0, 0,  0,            0,            32'hCAFE_F00D,1,1,0, 0,1, 6, 32'hCAFE_F00D,6};
        vecs[18] = '{1,0,0,0, 11, 32'h33,       0,            0,            0,0,0, 1,0, 11,32'h33,       7};
        vecs[19] = '{0,0,0,0, 0,  0,            0,            0,            0,0,0, 1,0, 11,32'h33,       8};

        drive(idle);
        rst = 1'b0;
        #12;
        check_outputs("reset", 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs("post_reset", 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_regw,
                          vecs[i].e_wreg, vecs[i].e_wdata, vecs[i].e_cnt);
        end

        // Reset asserted while a load is waiting for its data.
        @(negedge clk);
        drive(idle);
        in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b1; in_write_reg = 5'd8;
        @(posedge clk);
        #1;
        check_outputs("lw_enter", 1'b0, 1'b0, 5'd8, 32'h33, 32'd8);
        #2;
        drive(idle);
        rst = 1'b0;
        #1;
        check_outputs("lw_rst", 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        in_mem_ready = 1'b1; in_mem_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check_outputs("lw_rst_after", 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check_outputs("lw_rst_nowrite", 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
